// File: rtl/morse_encoder_gen.sv
//==============================================================================
// Module  : morse_encoder_gen
// Brief   : Keys out the Morse code for one letter (A..P), followed by a
//           3-unit gap. Optional loop-on-Repeat is built with MORSE_REPEAT_EN.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module morse_encoder_gen #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UNIT_HZ         = 2,
    parameter int LETTER_WIDTH    = 4
) (
    input  logic                    ClockIn,
    input  logic                    Resetn,
    input  logic                    Start,
    input  logic                    Abort,
    input  logic                    Repeat,
    input  logic [LETTER_WIDTH-1:0] Letter,
    output logic                    DotDashOut,
    output logic                    NewBitOut,
    output logic                    Busy,
    output logic                    Done
);

    localparam int                 c_TICK_DIV = CLOCK_FREQUENCY / UNIT_HZ;
    localparam int                 c_CNT_W    = $clog2(c_TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]         c_GAP_LAST = 4'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [3:0]              r_idx, w_idx_nxt;
    logic [LETTER_WIDTH-1:0] r_letter, w_letter_nxt;
    logic                    r_done, w_done_nxt;

    logic [3:0]  w_letter_ext;
    logic [3:0]  w_len;
    logic [15:0] w_pat;
    logic [3:0]  w_bit_sel;
    logic        w_last_tick;
    logic        w_last_bit;
    logic        w_repeat;

`ifdef MORSE_REPEAT_EN
    assign w_repeat = Repeat;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = Repeat;
    assign w_repeat        = 1'b0;
`endif

    always_comb begin
        w_letter_ext                   = '0;
        w_letter_ext[LETTER_WIDTH-1:0] = r_letter;
    end

    // Patterns are right-aligned; bit (len-1) is the first one keyed.
    always_comb begin
        w_len = 4'd1;
        w_pat = 16'b1;
        case (w_letter_ext)
            4'd0:  begin w_len = 4'd5;  w_pat = 16'b10111;         end
            4'd1:  begin w_len = 4'd9;  w_pat = 16'b111010101;     end
            4'd2:  begin w_len = 4'd11; w_pat = 16'b11101011101;   end
            4'd3:  begin w_len = 4'd7;  w_pat = 16'b1110101;       end
            4'd4:  begin w_len = 4'd1;  w_pat = 16'b1;             end
            4'd5:  begin w_len = 4'd9;  w_pat = 16'b101011101;     end
            4'd6:  begin w_len = 4'd9;  w_pat = 16'b111011101;     end
            4'd7:  begin w_len = 4'd7;  w_pat = 16'b1010101;       end
            4'd8:  begin w_len = 4'd3;  w_pat = 16'b101;           end
            4'd9:  begin w_len = 4'd13; w_pat = 16'b1011101110111; end
            4'd10: begin w_len = 4'd9;  w_pat = 16'b111010111;     end
            4'd11: begin w_len = 4'd9;  w_pat = 16'b101110101;     end
            4'd12: begin w_len = 4'd7;  w_pat = 16'b1110111;       end
            4'd13: begin w_len = 4'd5;  w_pat = 16'b11101;         end
            4'd14: begin w_len = 4'd11; w_pat = 16'b11101110111;   end
            default: begin w_len = 4'd11; w_pat = 16'b10111011101; end
        endcase
    end

    assign w_bit_sel   = w_len - 4'd1 - r_idx;
    assign w_last_tick = (r_cnt == c_CNT_LAST);
    assign w_last_bit  = (r_idx == (w_len - 4'd1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_letter_nxt = r_letter;
        w_done_nxt   = 1'b0;
        if (Abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        w_state_nxt  = S_SEND;
                        w_letter_nxt = Letter;
                        w_cnt_nxt    = '0;
                        w_idx_nxt    = 4'd0;
                    end
                end
                S_SEND: begin
                    if (w_last_tick) begin
                        w_cnt_nxt = '0;
                        if (w_last_bit) begin
                            w_state_nxt = S_GAP;
                            w_idx_nxt   = 4'd0;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_GAP: begin
                    // r_idx counts the three trailing gap units here
                    if (w_last_tick) begin
                        w_cnt_nxt = '0;
                        if (r_idx == c_GAP_LAST) begin
                            w_idx_nxt = 4'd0;
                            if (w_repeat) begin
                                w_state_nxt = S_SEND;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= 4'd0;
            r_letter <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_letter <= w_letter_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign DotDashOut = (r_state == S_SEND) && w_pat[w_bit_sel];
    assign Busy       = (r_state == S_SEND) || (r_state == S_GAP);
    assign NewBitOut  = Busy && (r_cnt == '0);
    assign Done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder_gen.sv
//==============================================================================
// Module  : tb_morse_encoder_gen
// Brief   : Scoreboard bench for morse_encoder_gen (TICK_DIV = 4).
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_morse_encoder_gen;

    logic       ClockIn = 1'b0;
    logic       Resetn  = 1'b0;
    logic       Start   = 1'b0;
    logic       Abort   = 1'b0;
    logic       Repeat  = 1'b0;
    logic [3:0] Letter  = 4'd0;
    logic       DotDashOut, NewBitOut, Busy, Done;

    morse_encoder_gen #(
        .CLOCK_FREQUENCY (8),
        .UNIT_HZ         (2),
        .LETTER_WIDTH    (4)
    ) u_dut (
        .ClockIn    (ClockIn),
        .Resetn     (Resetn),
        .Start      (Start),
        .Abort      (Abort),
        .Repeat     (Repeat),
        .Letter     (Letter),
        .DotDashOut (DotDashOut),
        .NewBitOut  (NewBitOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 ClockIn = ~ClockIn;

    typedef struct packed {
        logic dd;
        logic nb;
        logic busy;
        logic done;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc_no  = 0;
    string tag     = "";

    string c_morse [16] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                            "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--."};

    // Expands dots/dashes into units, then units into per-cycle expectations.
    task automatic push_letter(input string m, input int cut, input bit with_done);
        bit units[$];
        int cyc = 0;
        for (int i = 0; i < m.len(); i++) begin
            if (i > 0) units.push_back(1'b0);
            if (m[i] == 8'h2e) units.push_back(1'b1);
            else repeat (3) units.push_back(1'b1);
        end
        repeat (3) units.push_back(1'b0);
        foreach (units[u]) begin
            for (int t = 0; t < 4; t++) begin
                if (cut == 0 || cyc < cut) sb.push_back({units[u], (t == 0), 1'b1, 1'b0});
                cyc++;
            end
        end
        if (cut == 0 && with_done) sb.push_back(4'b0001);
    endtask

    task automatic push_idle(input int n);
        repeat (n) sb.push_back(4'b0000);
    endtask

    task automatic cmp(input string what, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s.%s cycle %0d observed %b expected %b", tag, what, cyc_no, got, exp);
        end
    endtask

    task automatic check_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge ClockIn);
            #1;
            cyc_no++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s.sb cycle %0d observed empty expected entry", tag, cyc_no);
            end else begin
                e = sb.pop_front();
                cmp("DotDashOut", DotDashOut, e.dd);
                cmp("NewBitOut",  NewBitOut,  e.nb);
                cmp("Busy",       Busy,       e.busy);
                cmp("Done",       Done,       e.done);
            end
        end
    endtask

    task automatic begin_letter(input string name, input logic [3:0] idx);
        tag    = name;
        cyc_no = 0;
        Letter = idx;
        Start  = 1'b1;
        check_cycles(1);
        Start  = 1'b0;
    endtask

    initial begin
        // reset state
        tag = "reset";
        repeat (2) @(posedge ClockIn);
        #1;
        cmp("DotDashOut", DotDashOut, 1'b0);
        cmp("NewBitOut",  NewBitOut,  1'b0);
        cmp("Busy",       Busy,       1'b0);
        cmp("Done",       Done,       1'b0);
        Resetn = 1'b1;
        push_idle(3);
        check_cycles(3);

        // E: one dot then gap, Done at cycle 17
        push_letter(".", 0, 1'b1);
        push_idle(2);
        begin_letter("E", 4'd4);
        check_cycles(sb.size());

        // A: Done at cycle 33
        push_letter(".-", 0, 1'b1);
        push_idle(2);
        begin_letter("A", 4'd0);
        check_cycles(sb.size());

        // Start and Letter change while busy have no effect
        push_letter(".-", 0, 1'b1);
        push_idle(2);
        begin_letter("A_restart", 4'd0);
        check_cycles(9);
        Start  = 1'b1;
        Letter = 4'd4;
        check_cycles(1);
        Start  = 1'b0;
        check_cycles(sb.size());

        // Abort during cycle 7: idle from cycle 8, never a Done
        push_letter(".-", 7, 1'b0);
        push_idle(30);
        begin_letter("A_abort", 4'd0);
        check_cycles(6);
        Abort = 1'b1;
        check_cycles(1);
        Abort = 1'b0;
        check_cycles(sb.size());

        // Abort beats a simultaneous Start
        tag    = "abort_start";
        cyc_no = 0;
        push_idle(4);
        Start  = 1'b1;
        Abort  = 1'b1;
        check_cycles(1);
        Start  = 1'b0;
        Abort  = 1'b0;
        check_cycles(3);

        // Asynchronous reset in cycle 6 of J
        push_letter(".---", 6, 1'b0);
        begin_letter("J_reset", 4'd9);
        check_cycles(5);
        Resetn = 1'b0;
        #1;
        cmp("DotDashOut", DotDashOut, 1'b0);
        cmp("NewBitOut",  NewBitOut,  1'b0);
        cmp("Busy",       Busy,       1'b0);
        cmp("Done",       Done,       1'b0);
        @(posedge ClockIn);
        #1;
        Resetn = 1'b1;
        push_idle(8);
        check_cycles(8);

        // Every letter of the table
        for (int i = 0; i < 16; i++) begin
            push_letter(c_morse[i], 0, 1'b1);
            push_idle(2);
            begin_letter($sformatf("L%0d", i), 4'(i));
            check_cycles(sb.size());
        end

`ifdef MORSE_REPEAT_EN
        // Repeat held through the last gap cycle: E restarts at cycle 17
        push_letter(".", 0, 1'b0);
        push_letter(".", 0, 1'b1);
        push_idle(2);
        Repeat = 1'b1;
        begin_letter("E_repeat", 4'd4);
        check_cycles(16);
        Repeat = 1'b0;
        check_cycles(sb.size());
`else
        // Repeat is ignored: E completes normally
        push_letter(".", 0, 1'b1);
        push_idle(2);
        Repeat = 1'b1;
        begin_letter("E_norepeat", 4'd4);
        check_cycles(sb.size());
        Repeat = 1'b0;
`endif

        tag = "final";
        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL final.sb observed %0d left expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
